regex_match_reporter: RTL and testbench
=======================================

Name: regex_match_reporter

Overview:
- Downstream consumer of the generated regex pipeline.
- Takes the per-word rule-match vector and its enable, accumulates per-frame statistics, and emits one report per frame over a valid/ready handshake.
- Sits between the matcher's match output and the core's result/descriptor logic.
- Frames that end while the previous report is still unconsumed are dropped and counted.

Parameters:
MATCH_W, 32, width of the rule-match vector from the matcher
POS_W, 16, width of the word-position and frame-length fields
CNT_W, 8, width of the saturating matched-word count and drop counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
en  in  1  input enable; 0 = ignore in_valid/in_last
in_valid  in  1  match word valid, aligned with match_in
match_in  in  MATCH_W  per-rule match flags for this word
in_last  in  1  final word of frame (qualified by in_valid)
rpt_valid  out  1  report available
rpt_ready  in  1  consumer accepts report
rpt_mask  out  MATCH_W  OR of all match_in words in frame
rpt_first_pos  out  POS_W  0-based index of first word with any match; all-ones if none
rpt_count  out  CNT_W  words with any match, saturating
rpt_words  out  POS_W  accepted words in frame, saturating
rpt_hit  out  1  rpt_mask != 0
drop_cnt  out  CNT_W  frames dropped on full report register, saturating

Behaviour:
- Accepted word: en && in_valid. Cycles where in_valid is 0 are gaps inside a frame: not counted, state held.
- Accumulator FSM:
  - IDLE: first accepted word moves to IN_FRAME, unless it also has in_last (single-word frame: close immediately, stay IDLE).
  - IN_FRAME: accepted word with in_last closes the frame and returns to IDLE.
- Per accepted word:
  - mask |= match_in
  - if match_in != 0 and no earlier hit: first_pos = pos
  - if match_in != 0: count += 1 (saturating)
  - pos += 1 (saturating at 2^POS_W-1)
- Frame close:
  - Closing word's contribution is included in the report.
  - Accumulators clear to mask=0, pos=0, count=0, first=all-ones in the same edge.
- Report register (EMPTY/FULL):
  - Close with EMPTY, or close with FULL && rpt_ready in the same cycle: load the report. rpt_valid=1 on the next cycle (latency 1 from the last-word edge).
  - Close with FULL && !rpt_ready: frame dropped, drop_cnt += 1 (saturating), accumulators still cleared.
  - rpt_valid && rpt_ready with no close: go EMPTY next cycle.
  - Report fields are stable while rpt_valid && !rpt_ready.
- en=0: input side frozen (no accumulation, no close). Output handshake still operates.
- Reset (rst_n=0 sampled at clk), including mid-frame:
  - FSM to IDLE, report register to EMPTY, accumulators cleared.
  - Outputs: rpt_valid=0, rpt_mask=0, rpt_first_pos=all-ones, rpt_count=0, rpt_words=0, rpt_hit=0, drop_cnt=0.
- Zero-match frame still reports: rpt_hit=0, rpt_first_pos=all-ones.
- No backpressure to upstream; the block accepts a word every cycle.

Decomposition:
- Package regex_rpt_pkg holds:
  - rpt_t struct (mask, first_pos, count, words, hit)
  - FIRST_NONE = all-ones of POS_W
  - acc_state_e {IDLE, IN_FRAME}
- Sub-module sat_counter #(W): synchronous clear, increment, saturate at max. Used for pos, count and drop_cnt.

Test Plan:
- Test 1, basic frame: rpt_ready=1; 4 accepted words, match_in = 0, 0x4, 0, 0x5, last on word 4 -> next cycle rpt_valid=1, mask=0x5, first_pos=1, count=2, words=4, hit=1.
- Test 2, gaps and no match: 3 accepted words, all match_in=0, with in_valid gaps between them -> words=3, count=0, hit=0, first_pos=0xFFFF.
- Test 3, backpressure: rpt_ready=0; two 1-word frames close -> first report held unchanged, drop_cnt=1. Raise rpt_ready -> first report consumed, rpt_valid=0 next cycle.
- Test 4, simultaneous consume and close: report pending; rpt_ready=1 in the same cycle a 1-word frame (match_in=0x8) closes -> drop_cnt unchanged, next cycle rpt_valid=1 with mask=0x8, first_pos=0.
- Test 5, enable and reset:
  - en=0 with 5 in_valid pulses, then en=1 and a 2-word frame -> words=2.
  - Separately: 2 matching words, rst_n=0 for one cycle, then 1-word frame with match_in=0 -> hit=0, words=1.
- Test 6, saturation: CNT_W=8; 300-word frame, every match_in=0x1 -> count=255, words=300, first_pos=0.

Source files
------------

// File: rtl/regex_rpt_pkg.sv
// Shared types and constants for the regex match reporter.
// Default widths match the matcher's generated pipeline.
package regex_rpt_pkg;

    localparam int DEF_MATCH_W = 32;
    localparam int DEF_POS_W   = 16;
    localparam int DEF_CNT_W   = 8;

    localparam logic [DEF_POS_W-1:0] FIRST_NONE = '1;

    typedef struct packed {
        logic [DEF_MATCH_W-1:0] mask;
        logic [DEF_POS_W-1:0]   first_pos;
        logic [DEF_CNT_W-1:0]   count;
        logic [DEF_POS_W-1:0]   words;
        logic                   hit;
    } rpt_t;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } acc_state_e;

endpackage

// File: rtl/regex_match_reporter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// o_cnt_inc is the would-be next value, used to fold in a closing word.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic [W-1:0] o_cnt_inc
);

    logic [W-1:0] r_cnt;
    logic         w_max;

    assign w_max     = &r_cnt;
    assign o_cnt_inc = w_max ? r_cnt : r_cnt + 1'b1;
    assign o_cnt     = r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= o_cnt_inc;
        end
    end

endmodule

// File: rtl/regex_match_reporter.sv
// Per-frame match statistics from the regex matcher, one report per frame.
// Frames closing while a report is still pending are dropped and counted.
module regex_match_reporter
    import regex_rpt_pkg::*;
#(
    parameter int MATCH_W = DEF_MATCH_W,
    parameter int POS_W   = DEF_POS_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    input  logic [MATCH_W-1:0] match_in,
    input  logic               in_last,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [MATCH_W-1:0] rpt_mask,
    output logic [POS_W-1:0]   rpt_first_pos,
    output logic [CNT_W-1:0]   rpt_count,
    output logic [POS_W-1:0]   rpt_words,
    output logic               rpt_hit,
    output logic [CNT_W-1:0]   drop_cnt
);

    acc_state_e r_state;
    acc_state_e w_state_next;

    logic               w_acc;
    logic               w_close;
    logic               w_any;
    logic               w_load;
    logic               w_drop;

    logic [MATCH_W-1:0] r_mask;
    logic [POS_W-1:0]   r_first;
    logic [POS_W-1:0]   w_pos;
    logic [POS_W-1:0]   w_pos_inc;
    logic [CNT_W-1:0]   w_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_drop_inc;

    logic [MATCH_W-1:0] w_rpt_mask;
    logic [POS_W-1:0]   w_rpt_first;
    logic [CNT_W-1:0]   w_rpt_count;

    logic               r_full;
    logic [MATCH_W-1:0] r_rpt_mask;
    logic [POS_W-1:0]   r_rpt_first;
    logic [CNT_W-1:0]   r_rpt_count;
    logic [POS_W-1:0]   r_rpt_words;

    assign w_acc   = en && in_valid;
    assign w_close = w_acc && in_last;
    assign w_any   = |match_in;
    assign w_load  = w_close && (!r_full || rpt_ready);
    assign w_drop  = w_close && r_full && !rpt_ready;

    sat_counter #(.W(POS_W)) u_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_close),
        .i_inc     (w_acc),
        .o_cnt     (w_pos),
        .o_cnt_inc (w_pos_inc)
    );

    sat_counter #(.W(CNT_W)) u_count (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_close),
        .i_inc     (w_acc && w_any),
        .o_cnt     (w_cnt),
        .o_cnt_inc (w_cnt_inc)
    );

    sat_counter #(.W(CNT_W)) u_drop (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (1'b0),
        .i_inc     (w_drop),
        .o_cnt     (drop_cnt),
        .o_cnt_inc (w_drop_inc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_acc) begin
            w_state_next = in_last ? IDLE : IN_FRAME;
        end
    end

    // An empty mask means no earlier word in this frame has hit.
    always_ff @(posedge clk) begin
        if (!rst_n || w_close) begin
            r_mask  <= '0;
            r_first <= '1;
        end else if (w_acc) begin
            r_mask <= r_mask | match_in;
            if (w_any && (r_mask == '0)) begin
                r_first <= w_pos;
            end
        end
    end

    // Fold the closing word into the report values.
    always_comb begin
        w_rpt_mask  = r_mask | match_in;
        w_rpt_first = r_first;
        w_rpt_count = w_cnt;
        if (w_any) begin
            w_rpt_count = w_cnt_inc;
            if (r_mask == '0) begin
                w_rpt_first = w_pos;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full      <= 1'b0;
            r_rpt_mask  <= '0;
            r_rpt_first <= '1;
            r_rpt_count <= '0;
            r_rpt_words <= '0;
        end else if (w_load) begin
            r_full      <= 1'b1;
            r_rpt_mask  <= w_rpt_mask;
            r_rpt_first <= w_rpt_first;
            r_rpt_count <= w_rpt_count;
            r_rpt_words <= w_pos_inc;
        end else if (r_full && rpt_ready) begin
            r_full <= 1'b0;
        end
    end

    assign rpt_valid     = r_full;
    assign rpt_mask      = r_rpt_mask;
    assign rpt_first_pos = r_rpt_first;
    assign rpt_count     = r_rpt_count;
    assign rpt_words     = r_rpt_words;
    assign rpt_hit       = |r_rpt_mask;

endmodule

// File: tb/tb_regex_match_reporter.sv
// Directed bench for regex_match_reporter with a frame-level reference model.
module tb_regex_match_reporter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        in_valid;
    logic [31:0] match_in;
    logic        in_last;
    logic        rpt_valid;
    logic        rpt_ready;
    logic [31:0] rpt_mask;
    logic [15:0] rpt_first_pos;
    logic [7:0]  rpt_count;
    logic [15:0] rpt_words;
    logic        rpt_hit;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;
    bit armed = 0;

    regex_match_reporter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .in_valid      (in_valid),
        .match_in      (match_in),
        .in_last       (in_last),
        .rpt_valid     (rpt_valid),
        .rpt_ready     (rpt_ready),
        .rpt_mask      (rpt_mask),
        .rpt_first_pos (rpt_first_pos),
        .rpt_count     (rpt_count),
        .rpt_words     (rpt_words),
        .rpt_hit       (rpt_hit),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: buffer the whole frame, summarise it at close.
    logic [31:0] q_frame[$];
    bit          m_valid = 0;
    int          m_drop  = 0;
    logic [31:0] m_mask;
    int          m_first;
    int          m_count;
    int          m_words;

    always @(posedge clk) begin
        if (!rst_n) begin
            q_frame.delete();
            m_valid = 0;
            m_drop  = 0;
        end else begin
            if (en && in_valid) q_frame.push_back(match_in);
            if (en && in_valid && in_last) begin
                if (!m_valid || rpt_ready) begin
                    m_mask  = 0;
                    m_first = -1;
                    m_count = 0;
                    foreach (q_frame[i]) begin
                        m_mask = m_mask | q_frame[i];
                        if (q_frame[i] != 0) begin
                            m_count++;
                            if (m_first < 0) m_first = i;
                        end
                    end
                    m_count = (m_count > 255) ? 255 : m_count;
                    m_words = (q_frame.size() > 65535) ? 65535
                                                       : q_frame.size();
                    m_valid = 1;
                end else begin
                    m_drop++;
                end
                q_frame.delete();
            end else if (m_valid && rpt_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            logic [15:0] ef;
            logic [7:0]  ed;
            bit ok;
            ef = (m_first < 0) ? 16'hFFFF : 16'(m_first);
            ed = (m_drop > 255) ? 8'd255 : 8'(m_drop);
            ok = (rpt_valid === m_valid) && (drop_cnt === ed);
            if (m_valid) begin
                ok = ok && (rpt_mask === m_mask)
                        && (rpt_first_pos === ef)
                        && (rpt_count === 8'(m_count))
                        && (rpt_words === 16'(m_words))
                        && (rpt_hit === (m_mask != 0));
            end
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL model t=%0t valid=%0b/%0b mask=%h/%h first=%h/%h cnt=%0d/%0d words=%0d/%0d hit=%0b drop=%0d/%0d",
                         $time, rpt_valid, m_valid, rpt_mask, m_mask,
                         rpt_first_pos, ef, rpt_count, m_count,
                         rpt_words, m_words, rpt_hit, drop_cnt, ed);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic word(input logic [31:0] m, input logic last);
        in_valid = 1'b1;
        match_in = m;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        match_in = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        in_valid  = 1'b0;
        match_in  = '0;
        in_last   = 1'b0;
        rpt_ready = 1'b1;
        idle(2);
        chk("rst_valid", 32'(rpt_valid), 0);
        chk("rst_mask", rpt_mask, 0);
        chk("rst_first", 32'(rpt_first_pos), 32'hFFFF);
        chk("rst_count", 32'(rpt_count), 0);
        chk("rst_words", 32'(rpt_words), 0);
        chk("rst_hit", 32'(rpt_hit), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        armed = 1;
        rst_n = 1'b1;
        idle(1);

        word(0, 0); word(4, 0); word(0, 0); word(5, 1);
        chk("t1_valid", 32'(rpt_valid), 1);
        chk("t1_mask", rpt_mask, 5);
        chk("t1_first", 32'(rpt_first_pos), 1);
        chk("t1_count", 32'(rpt_count), 2);
        chk("t1_words", 32'(rpt_words), 4);
        chk("t1_hit", 32'(rpt_hit), 1);
        idle(1);
        chk("t1_consumed", 32'(rpt_valid), 0);

        word(0, 0); idle(2); word(0, 0); idle(1); word(0, 1);
        chk("t2_words", 32'(rpt_words), 3);
        chk("t2_count", 32'(rpt_count), 0);
        chk("t2_hit", 32'(rpt_hit), 0);
        chk("t2_first", 32'(rpt_first_pos), 32'hFFFF);
        idle(1);

        rpt_ready = 1'b0;
        word(1, 1); word(2, 1);
        chk("t3_drop", 32'(drop_cnt), 1);
        idle(2);
        chk("t3_held_valid", 32'(rpt_valid), 1);
        chk("t3_held_mask", rpt_mask, 1);
        rpt_ready = 1'b1;
        idle(1);
        chk("t3_consumed", 32'(rpt_valid), 0);

        rpt_ready = 1'b0;
        word(3, 1);
        rpt_ready = 1'b1;
        word(8, 1);
        chk("t4_valid", 32'(rpt_valid), 1);
        chk("t4_mask", rpt_mask, 8);
        chk("t4_first", 32'(rpt_first_pos), 0);
        chk("t4_drop", 32'(drop_cnt), 1);
        idle(1);

        en = 1'b0;
        repeat (5) word(7, 1);
        chk("t5_en_off", 32'(rpt_valid), 0);
        en = 1'b1;
        word(0, 0); word(0, 1);
        chk("t5_words", 32'(rpt_words), 2);
        idle(1);
        word(1, 0); word(1, 0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("t5_rst_drop", 32'(drop_cnt), 0);
        word(0, 1);
        chk("t5_hit", 32'(rpt_hit), 0);
        chk("t5_words1", 32'(rpt_words), 1);
        idle(1);

        for (int i = 0; i < 299; i++) word(1, 0);
        word(1, 1);
        chk("t6_count", 32'(rpt_count), 255);
        chk("t6_words", 32'(rpt_words), 300);
        chk("t6_first", 32'(rpt_first_pos), 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
